// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB bus arbiter: arbiter state enum, HTRANS
// encodings, tenure-counter width and bus-width macros used on the ports.
`ifndef HTRANS_WIDTH
`define HTRANS_WIDTH 2
`endif
`ifndef HMASTER_WIDTH
`define HMASTER_WIDTH 4
`endif

package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,   // default master parked, nobody requesting
    ST_OWN  = 2'd1,   // a requester owns the bus, tenure limit active
    ST_LOCK = 2'd2    // locked owner, no re-arbitration on tenure
  } arb_state_e;

  localparam logic [`HTRANS_WIDTH-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [`HTRANS_WIDTH-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [`HTRANS_WIDTH-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [`HTRANS_WIDTH-1:0] HTRANS_SEQ    = 2'b11;

  localparam int TENURE_W = 8;

  // A transfer type that moves data and therefore consumes tenure.
  function automatic logic is_beat(input logic [`HTRANS_WIDTH-1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational pointer-rotated priority picker. The search starts at
// (ptr_i + 1) mod N, so ptr_i is the index of the last winner; passing
// N-1 turns it into a plain lowest-index-first picker.
module ahb_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             start;
  int             first;
  int             sum;

  // Rotate the request vector so the search start lands on bit 0, find the
  // lowest set bit, then rotate the position back into a master index.
  always_comb begin
    start   = (int'(ptr_i) + 1) % N;
    req_dbl = {req_i, req_i} >> start;
    req_rot = req_dbl[N-1:0];
    first   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) first = k;
    end
    sum = start + first;
    if (sum >= N) sum = sum - N;
    idx_o   = sum[IW-1:0];
    valid_o = |req_i;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt_o[gi] = valid_o && (idx_o == IW'(gi));
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant with tenure limit, locked sequences
// and default-master parking. Define AHB_ARB_FIXED_PRIO_EN to replace the
// round-robin search with fixed lowest-index-first priority.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_TENURE     = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [NUM_MASTERS-1:0]    HBUSREQ,
  input  logic [NUM_MASTERS-1:0]    HLOCK,
  input  logic [`HTRANS_WIDTH-1:0]  HTRANS,
  input  logic                      HREADY,
  output logic [NUM_MASTERS-1:0]    HGRANT,
  output logic [`HMASTER_WIDTH-1:0] HMASTER,
  output logic                      HMASTLOCK
);

  localparam int                      IW         = `HMASTER_WIDTH;
  localparam logic [IW-1:0]           DEF_IDX    = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]  DEF_GNT    = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [TENURE_W-1:0]     TENURE_MAX = TENURE_W'(MAX_TENURE);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [IW-1:0]          hmaster_q;
  logic                   hmastlock_q;
  logic [TENURE_W-1:0]    tenure_q;

  logic [IW-1:0]          pick_ptr;
  logic [IW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic                   pick_lock;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   release_bus;
  logic                   tenure_hit;
  logic                   arb_point;

`ifdef AHB_ARB_FIXED_PRIO_EN
  // Pointer at the top index makes the picker start its search at master 0.
  assign pick_ptr = IW'(NUM_MASTERS - 1);
`else
  assign pick_ptr = rr_ptr_q;
`endif

  ahb_arb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i   (HBUSREQ),
    .ptr_i   (pick_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Decide whether this HREADY cycle is an arbitration point. The grant
  // vector is one-hot, so masking with it selects the owner's bits.
  always_comb begin
    owner_req   = |(HBUSREQ & hgrant_q);
    owner_lock  = |(HLOCK & hgrant_q);
    pick_lock   = |(HLOCK & pick_gnt);
    release_bus = (HTRANS == HTRANS_IDLE) || !owner_req;
    tenure_hit  = (tenure_q == TENURE_MAX) && (HTRANS != HTRANS_BUSY);
    if (state_q == ST_LOCK) begin
      arb_point = HREADY && release_bus && !owner_lock;
    end else begin
      arb_point = HREADY && (release_bus || tenure_hit);
    end
  end

  // Arbiter FSM: grant, address-phase owner, lock flag and tenure counter
  // all advance together on HREADY cycles and freeze while HREADY is low.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_PARK;
      hgrant_q    <= DEF_GNT;
      owner_q     <= DEF_IDX;
      rr_ptr_q    <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      tenure_q    <= '0;
    end else if (HREADY) begin
      // Address phase follows the grant by one HREADY cycle.
      hmaster_q   <= owner_q;
      hmastlock_q <= owner_lock;
      if (arb_point) begin
        // Any re-arbitration restarts tenure, even when the same master wins.
        tenure_q <= '0;
        if (pick_valid) begin
          owner_q  <= pick_idx;
          hgrant_q <= pick_gnt;
          rr_ptr_q <= pick_idx;
          state_q  <= pick_lock ? ST_LOCK : ST_OWN;
        end else begin
          owner_q  <= DEF_IDX;
          hgrant_q <= DEF_GNT;
          state_q  <= ST_PARK;
        end
      end else if (is_beat(HTRANS) && (tenure_q != TENURE_MAX)) begin
        tenure_q <= tenure_q + TENURE_W'(1);
      end
    end
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter (4 masters, tenure limit 4).
module tb_ahb_bus_arbiter;

  localparam int NM    = 4;
  localparam int MAX_T = 4;
  localparam int DEF_M = 0;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [3:0] HMASTER;
  logic       HMASTLOCK;

  int errors = 0;
  int checks = 0;

  // Reference model state: who holds the grant, who won last, beats used,
  // whether the owner is locked, and the address-phase owner/lock.
  int m_owner;
  int m_last;
  int m_beats;
  int m_mstr;
  bit m_locked;
  bit m_mlock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] tr;
    logic       rdy;
    logic [3:0] gnt;
    logic [3:0] mst;
    logic       ml;
  } vec_t;

  vec_t vecs[11];
  logic [3:0] lock_r;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .MAX_TENURE     (MAX_T),
    .DEFAULT_MASTER (DEF_M)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  // Winner among requesters, or -1 when nobody asks.
  function automatic int winner(input logic [3:0] req, input int last);
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NM; i++) if (bit_of(req, i)) return i;
`else
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (last + k) % NM;
      if (bit_of(req, c)) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                            input logic [1:0] tr, input logic rdy);
    bit rel;
    bit rearb;
    int w;
    if (rst) begin
      m_owner = DEF_M; m_last = DEF_M; m_beats = 0;
      m_locked = 0; m_mstr = DEF_M; m_mlock = 0;
      return;
    end
    if (!rdy) return;
    m_mstr  = m_owner;
    m_mlock = bit_of(lock, m_owner);
    rel = (tr == T_IDLE) || !bit_of(req, m_owner);
    if (m_locked) rearb = rel && !bit_of(lock, m_owner);
    else          rearb = rel || (m_beats == MAX_T && tr != T_BUSY);
    if (rearb) begin
      w = winner(req, m_last);
      if (w < 0) begin
        m_owner = DEF_M; m_locked = 0;
      end else begin
        m_owner = w; m_last = w; m_locked = bit_of(lock, w);
      end
      m_beats = 0;
    end else if ((tr == T_NSEQ || tr == T_SEQ) && m_beats < MAX_T) begin
      m_beats++;
    end
  endtask

  // One bus cycle: drive, advance the model, clock, compare against the model.
  task automatic cycle(input string tag, input logic rst, input logic [3:0] req,
                       input logic [3:0] lock, input logic [1:0] tr, input logic rdy);
    hreset = rst; HBUSREQ = req; HLOCK = lock; HTRANS = tr; HREADY = rdy;
    model_step(rst, req, lock, tr, rdy);
    @(posedge hclk);
    #1;
    $display("[%s] rst=%b req=%b lock=%b tr=%0d rdy=%b -> gnt=%b mst=%0d mlock=%b",
             tag, rst, req, lock, tr, rdy, HGRANT, HMASTER, HMASTLOCK);
    check({tag, ".gnt"},   int'(HGRANT),    1 << m_owner);
    check({tag, ".mst"},   int'(HMASTER),   m_mstr);
    check({tag, ".mlock"}, int'(HMASTLOCK), int'(m_mlock));
  endtask

  task automatic do_reset();
    cycle("rst", 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1);
    cycle("rst", 1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b0);
  endtask

  initial begin
    hreset = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = T_IDLE; HREADY = 1'b1;
    m_owner = DEF_M; m_last = DEF_M; m_beats = 0; m_locked = 0; m_mstr = DEF_M; m_mlock = 0;

`ifdef AHB_ARB_FIXED_PRIO_EN
    vecs[0]  = '{4'b1010, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd0, 1'b0};
    vecs[1]  = '{4'b1010, 4'b0000, T_NSEQ, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[2]  = '{4'b1010, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[3]  = '{4'b1010, 4'b0000, T_NSEQ, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[4]  = '{4'b1010, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[5]  = '{4'b1000, 4'b0000, T_IDLE, 1'b1, 4'b1000, 4'd1, 1'b0};
    vecs[6]  = '{4'b1010, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd3, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 4'd1, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 4'd0, 1'b0};
    vecs[9]  = '{4'b1110, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd0, 1'b0};
    vecs[10] = '{4'b1110, 4'b0000, T_NSEQ, 1'b1, 4'b0010, 4'd1, 1'b0};
`else
    vecs[0]  = '{4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd0, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b0010, 4'd1, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0100, 4'd1, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b0100, 4'd2, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b1000, 4'd2, 1'b0};
    vecs[5]  = '{4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b1000, 4'd3, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0001, 4'd3, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b0001, 4'd0, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0010, 4'd0, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 4'd1, 1'b0};
    vecs[10] = '{4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 4'd0, 1'b0};
`endif

    // Reset state with no requests: parked on master 0.
    do_reset();
    check("reset.gnt",   int'(HGRANT),    1);
    check("reset.mst",   int'(HMASTER),   0);
    check("reset.mlock", int'(HMASTLOCK), 0);
    cycle("park", 1'b0, 4'b0000, 4'b0000, T_IDLE, 1'b1);
    check("park.gnt", int'(HGRANT), 1);

    // Table vectors: grant rotation / fixed priority.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle("vec", 1'b0, vecs[i].req, vecs[i].lock, vecs[i].tr, vecs[i].rdy);
      check($sformatf("vec%0d.gnt", i),   int'(HGRANT),    int'(vecs[i].gnt));
      check($sformatf("vec%0d.mst", i),   int'(HMASTER),   int'(vecs[i].mst));
      check($sformatf("vec%0d.mlock", i), int'(HMASTLOCK), int'(vecs[i].ml));
    end

    // Tenure expiry with an HREADY stall and a BUSY at the expiry point.
    do_reset();
    cycle("ten", 1'b0, 4'b0100, 4'b0000, T_IDLE, 1'b1);
    check("ten.own", int'(HGRANT), 4'b0100);
    cycle("ten", 1'b0, 4'b0110, 4'b0000, T_NSEQ, 1'b1);
    repeat (3) cycle("ten", 1'b0, 4'b0110, 4'b0000, T_SEQ, 1'b1);
    check("ten.beat4.gnt", int'(HGRANT), 4'b0100);
    check("ten.beat4.mst", int'(HMASTER), 2);
    for (int i = 0; i < 5; i++) begin
      cycle("stall", 1'b0, 4'b0110, 4'b0000, T_SEQ, 1'b0);
      check("stall.gnt", int'(HGRANT), 4'b0100);
      check("stall.mst", int'(HMASTER), 2);
    end
    cycle("busy", 1'b0, 4'b0110, 4'b0000, T_BUSY, 1'b1);
    check("busy.gnt", int'(HGRANT), 4'b0100);
    cycle("expire", 1'b0, 4'b0110, 4'b0000, T_SEQ, 1'b1);
    check("expire.gnt", int'(HGRANT), 4'b0010);
    check("expire.mst", int'(HMASTER), 2);
    cycle("handover", 1'b0, 4'b0010, 4'b0000, T_NSEQ, 1'b1);
    check("handover.mst", int'(HMASTER), 1);

    // Lone owner re-granted on expiry with a fresh tenure.
    do_reset();
    cycle("solo", 1'b0, 4'b0100, 4'b0000, T_IDLE, 1'b1);
    cycle("solo", 1'b0, 4'b0100, 4'b0000, T_NSEQ, 1'b1);
    repeat (3) cycle("solo", 1'b0, 4'b0100, 4'b0000, T_SEQ, 1'b1);
    cycle("solo", 1'b0, 4'b0100, 4'b0000, T_SEQ, 1'b1);
    check("solo.regrant", int'(HGRANT), 4'b0100);
    for (int i = 0; i < 4; i++) begin
      cycle("solo2", 1'b0, 4'b0110, 4'b0000, T_SEQ, 1'b1);
      check("solo2.hold", int'(HGRANT), 4'b0100);
    end
    cycle("solo2", 1'b0, 4'b0110, 4'b0000, T_SEQ, 1'b1);
    check("solo2.switch", int'(HGRANT), 4'b0010);

    // Locked sequence from master 3 outlasts the tenure limit.
    do_reset();
    cycle("lock", 1'b0, 4'b1000, 4'b1000, T_IDLE, 1'b1);
    check("lock.gnt", int'(HGRANT), 4'b1000);
    cycle("lock", 1'b0, 4'b1001, 4'b1000, T_NSEQ, 1'b1);
    for (int i = 0; i < 19; i++) begin
      cycle("lock", 1'b0, 4'b1001, 4'b1000, T_SEQ, 1'b1);
      check("lock.hold", int'(HGRANT), 4'b1000);
      check("lock.mlock", int'(HMASTLOCK), 1);
      check("lock.mst", int'(HMASTER), 3);
    end
    cycle("lockidle", 1'b0, 4'b1001, 4'b1000, T_IDLE, 1'b1);
    check("lockidle.gnt", int'(HGRANT), 4'b1000);
    cycle("unlock", 1'b0, 4'b1001, 4'b0000, T_SEQ, 1'b1);
    check("unlock.gnt", int'(HGRANT), 4'b1000);
    cycle("unlock", 1'b0, 4'b1001, 4'b0000, T_IDLE, 1'b1);
    check("unlock.switch", int'(HGRANT), 4'b0001);

    // Reset mid-lock with HREADY low still takes effect.
    do_reset();
    cycle("rlock", 1'b0, 4'b1000, 4'b1000, T_IDLE, 1'b1);
    cycle("rlock", 1'b0, 4'b1001, 4'b1000, T_SEQ, 1'b1);
    cycle("rlock", 1'b1, 4'b1001, 4'b1000, T_SEQ, 1'b0);
    check("rlock.gnt",   int'(HGRANT),    1);
    check("rlock.mst",   int'(HMASTER),   0);
    check("rlock.mlock", int'(HMASTLOCK), 0);

    // Randomised traffic against the reference model.
    do_reset();
    lock_r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rq;
      logic [1:0] tr;
      logic       rdy;
      logic       rst;
      if (i % 8 == 0) lock_r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rq  = 4'($urandom_range(0, 15));
      tr  = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle("rand", rst, rq, lock_r & rq, tr, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
